ex_muldiv: RTL and testbench
============================

Name: ex_muldiv

Overview:
Iterative RV32M multiply/divide unit in the EX stage. It consumes the operands and operation held in the ID/EX pipeline register. It drives a stall request back to the IF/ID and ID/EX registers, so they hold the instruction until the result is ready. On completion it presents a 32-bit result for the EX/MEM register to capture.

Parameters:
XLEN, 32, operand/result width; iteration count = XLEN; counter width = $clog2(XLEN)+1

Ports:
clk  in  1  pipeline clock, rising edge
reset  in  1  asynchronous, active-low; 0 = reset asserted
StartE  in  1  valid M-extension op present in EX (from ID/EX)
FlushE  in  1  synchronous kill of the in-flight op (branch/jump redirect)
MulDivOpE  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
SrcAE  in  XLEN  rs1 operand
SrcBE  in  XLEN  rs2 operand
StallE  out  1  hold IF/ID and ID/EX registers (combinational)
DoneE  out  1  result valid this cycle (registered)
ResultE  out  XLEN  result (registered)

Behaviour:
- States: IDLE, CALC, DONE.
- Reset (reset==0, async): state=IDLE, counter=0, ResultE=0, DoneE=0, all internal registers 0. StallE is forced to 0 while reset is low. Reset mid-operation aborts the op with no DoneE.
- IDLE, StartE=1, FlushE=0 at edge T:
  - Latch op, operand magnitudes and sign flags.
  - MULH: both operands signed. MULHSU: A signed, B unsigned. MULHU, DIVU, REMU: both unsigned. DIV/REM: both signed.
  - Go to CALC with counter=0.
- Fast path for divide ops, checked at the same edge, go directly to DONE:
  - Divide by zero (SrcBE==0): DIV/DIVU result = 0xFFFFFFFF; REM/REMU result = SrcAE.
  - Signed overflow (DIV/REM, SrcAE=0x80000000, SrcBE=0xFFFFFFFF): DIV result = 0x80000000; REM result = 0.
- CALC performs one iteration per cycle and increments the counter.
  - Multiply: radix-2 shift-add on magnitudes into a 2*XLEN-bit product.
  - Divide: restoring division on magnitudes, producing quotient and remainder.
- Leaving CALC: after XLEN iterations (counter==XLEN-1 at the edge), go to DONE.
  - Load ResultE with the sign-corrected value.
  - MUL: low XLEN bits. MULH/MULHSU/MULHU: high XLEN bits. Product is negated when the operand signs differ (signed ops only).
  - Quotient is negated when the signs differ. Remainder takes the dividend's sign.
- DONE lasts exactly one cycle with DoneE=1, then returns to IDLE.
- DoneE is 0 in every other state. ResultE holds its value until the next load.
- StallE = (IDLE & StartE & ~FlushE) | CALC. StallE is 0 in DONE, so the pipeline advances at the end of DONE.
- Normal latency: start seen in cycle T, DoneE in cycle T+XLEN+1 (T+33). StallE is high for XLEN+1 cycles.
- Fast-path latency: DoneE in T+1; StallE is high in cycle T only.
- StartE is ignored in CALC and DONE, because ID/EX is held and StartE stays high.
- FlushE=1 in any state: next state IDLE, counter=0, DoneE=0, ResultE unchanged. FlushE takes precedence over StartE. StallE is 0 during the flush cycle.
- Back-to-back ops: a new StartE in the cycle after DONE starts a new operation normally.

Test Plan:
- MUL SrcAE=7, SrcBE=0xFFFFFFFD at cycle T -> StallE high T..T+32; DoneE=1 only at T+33; ResultE=0xFFFFFFEB.
- MULHU 0xFFFFFFFF*0xFFFFFFFF -> ResultE=0xFFFFFFFE. MULH with the same operands -> 0x00000000. MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD. REM with the same operands -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- Fast path:
  - DIVU 5/0 -> 0xFFFFFFFF.
  - REM 5/0 -> 5.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000.
  - REM 0x80000000/0xFFFFFFFF -> 0.
  - For all four: DoneE at T+1 and StallE high only in cycle T.
- FlushE pulsed at T+10 of a DIV -> StallE=0 that cycle, state IDLE at T+11, no DoneE pulse, ResultE keeps its prior value. A new MUL 3*4 at T+12 -> 12 at T+45.
- reset driven low asynchronously at T+5 mid-MUL -> StallE=0, DoneE=0, ResultE=0 immediately. After release, a MUL 2*3 completes 6 with full 33-cycle latency.

Source files
------------

// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit for the EX stage.
// Signed operations are handled as magnitudes, with a sign correction applied
// when the result is loaded. The multiply (shift-add) and the restoring divide
// share one 2*XLEN accumulator:
//   multiply: upper half = partial product, lower half = multiplier bits
//   divide:   upper half = partial remainder, lower half = dividend/quotient
module ex_muldiv #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            StartE,
    input  logic            FlushE,
    input  logic [2:0]      MulDivOpE,
    input  logic [XLEN-1:0] SrcAE,
    input  logic [XLEN-1:0] SrcBE,
    output logic            StallE,
    output logic            DoneE,
    output logic [XLEN-1:0] ResultE
);
    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      op_q, op_d;
    logic [XLEN-1:0] bmag_q, bmag_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic            negq_q, negq_d;   // negate product / quotient
    logic            negr_q, negr_d;   // negate remainder (dividend sign)
    logic [XLEN-1:0] res_q, res_d;
    logic            done_q, done_d;

    // Operand decode for a new op: signedness, magnitudes, divide fast paths
    logic            is_div, sgn_a, sgn_b, a_neg, b_neg, div_zero, div_ovf;
    logic [XLEN-1:0] a_mag, b_mag, fast_res;

    always_comb begin
        is_div   = MulDivOpE[2];
        sgn_a    = (MulDivOpE == 3'b001) || (MulDivOpE == 3'b010) ||
                   (MulDivOpE == 3'b100) || (MulDivOpE == 3'b110);
        sgn_b    = (MulDivOpE == 3'b001) || (MulDivOpE == 3'b100) ||
                   (MulDivOpE == 3'b110);
        a_neg    = sgn_a && SrcAE[XLEN-1];
        b_neg    = sgn_b && SrcBE[XLEN-1];
        a_mag    = a_neg ? (~SrcAE + 1'b1) : SrcAE;
        b_mag    = b_neg ? (~SrcBE + 1'b1) : SrcBE;
        div_zero = is_div && (SrcBE == '0);
        div_ovf  = is_div && !MulDivOpE[0] && (SrcAE == MIN_NEG) && (SrcBE == '1);
        if (div_zero)
            fast_res = MulDivOpE[1] ? SrcAE : '1;
        else
            fast_res = MulDivOpE[1] ? '0 : MIN_NEG;
    end

    // One iteration of shift-add multiply or restoring divide, plus the
    // sign-corrected result taken from the final iteration
    logic [XLEN:0]     mul_sum, div_shl, div_trial;
    logic [2*XLEN-1:0] mul_nxt, div_nxt, iter, prod_s;
    logic [XLEN-1:0]   quo, rem, fin_res;

    always_comb begin
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, bmag_q} : '0);
        mul_nxt   = {mul_sum, acc_q[XLEN-1:1]};
        div_shl   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        div_trial = div_shl - {1'b0, bmag_q};
        if (!div_trial[XLEN])
            div_nxt = {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        else
            div_nxt = {div_shl[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
        iter   = op_q[2] ? div_nxt : mul_nxt;
        prod_s = negq_q ? (~iter + 1'b1) : iter;
        quo    = iter[XLEN-1:0];
        rem    = iter[2*XLEN-1:XLEN];
        if (op_q[2])
            fin_res = op_q[1] ? (negr_q ? (~rem + 1'b1) : rem)
                              : (negq_q ? (~quo + 1'b1) : quo);
        else
            fin_res = (op_q[1:0] == 2'b00) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
    end

    // Next-state and datapath control
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        bmag_d  = bmag_q;
        acc_d   = acc_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        res_d   = res_q;
        done_d  = 1'b0;
        StallE  = 1'b0;
        if (FlushE) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: if (StartE) begin
                    StallE = 1'b1;
                    op_d   = MulDivOpE;
                    bmag_d = b_mag;
                    acc_d  = {{XLEN{1'b0}}, a_mag};
                    negq_d = a_neg ^ b_neg;
                    negr_d = a_neg;
                    cnt_d  = '0;
                    if (div_zero || div_ovf) begin
                        res_d   = fast_res;
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = CALC;
                    end
                end
                CALC: begin
                    StallE = 1'b1;
                    acc_d  = iter;
                    cnt_d  = cnt_q + 1'b1;
                    if (cnt_q == CW'(XLEN-1)) begin
                        res_d   = fin_res;
                        done_d  = 1'b1;
                        state_d = DONE;
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
        if (!reset) StallE = 1'b0;
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            bmag_q  <= '0;
            acc_q   <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            res_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            bmag_q  <= bmag_d;
            acc_q   <= acc_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            res_q   <= res_d;
            done_q  <= done_d;
        end
    end

    assign DoneE   = done_q;
    assign ResultE = res_q;
endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv: expected results are queued at issue and
// compared when DoneE appears, together with latency and stall-cycle counts.
module tb_ex_muldiv;
    logic        clk = 1'b0;
    logic        reset, StartE, FlushE;
    logic [2:0]  MulDivOpE;
    logic [31:0] SrcAE, SrcBE;
    logic        StallE, DoneE;
    logic [31:0] ResultE;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] sb_q[$];
    logic [31:0] last_res;

    ex_muldiv #(.XLEN(32)) dut (
        .clk(clk), .reset(reset), .StartE(StartE), .FlushE(FlushE),
        .MulDivOpE(MulDivOpE), .SrcAE(SrcAE), .SrcBE(SrcBE),
        .StallE(StallE), .DoneE(DoneE), .ResultE(ResultE)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one op at the next falling edge (cycle T) and follow it to DoneE.
    task automatic do_op(input string tag, input logic [2:0] o, input logic [31:0] x,
                         input logic [31:0] y, input logic [31:0] exp, input int lat);
        int stalls;
        int done_n;
        logic [31:0] e;
        @(negedge clk);
        StartE = 1'b1; MulDivOpE = o; SrcAE = x; SrcBE = y;
        sb_q.push_back(exp);
        #1;
        chk({tag, " done_at_start"}, 32'(DoneE), 32'd0);
        stalls = int'(StallE);
        done_n = 0;
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk); #1;
            if (DoneE) begin
                done_n = n;
                break;
            end
            stalls += int'(StallE);
        end
        StartE = 1'b0;
        chk({tag, " latency"}, 32'(done_n), 32'(lat));
        chk({tag, " stall_cycles"}, 32'(stalls), 32'(lat));
        chk({tag, " stall_in_done"}, 32'(StallE), 32'd0);
        e = (sb_q.size() > 0) ? sb_q.pop_front() : 32'hDEADBEEF;
        chk({tag, " result"}, ResultE, e);
        last_res = e;
    endtask

    initial begin
        reset = 1'b0; StartE = 1'b1; FlushE = 1'b0;
        MulDivOpE = 3'b000; SrcAE = 32'd1; SrcBE = 32'd1;
        last_res = 32'd0;
        #12;
        chk("reset stall", 32'(StallE), 32'd0);
        chk("reset done", 32'(DoneE), 32'd0);
        chk("reset result", ResultE, 32'd0);
        @(negedge clk);
        StartE = 1'b0;
        reset  = 1'b1;

        // Iterative ops, issued back-to-back
        do_op("mul",    3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33);
        do_op("mulhu",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
        do_op("mulh",   3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33);
        do_op("mulhsu", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33);
        do_op("div",    3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33);
        do_op("rem",    3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33);
        do_op("divu",   3'b101, 32'd100,      32'd7,        32'd14,       33);
        do_op("remu",   3'b111, 32'd100,      32'd7,        32'd2,        33);

        // Divide fast paths
        do_op("divu_by0", 3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 1);
        do_op("rem_by0",  3'b110, 32'd5,        32'd0,        32'd5,        1);
        do_op("div_ovf",  3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
        do_op("rem_ovf",  3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1);

        // Flush in the middle of a divide: nothing may complete
        @(negedge clk);
        StartE = 1'b1; MulDivOpE = 3'b100; SrcAE = 32'd100; SrcBE = 32'd7;
        repeat (10) @(negedge clk);
        FlushE = 1'b1; StartE = 1'b0;
        #1;
        chk("flush stall", 32'(StallE), 32'd0);
        @(negedge clk);
        FlushE = 1'b0;
        #1;
        chk("after flush stall", 32'(StallE), 32'd0);
        chk("after flush done", 32'(DoneE), 32'd0);
        chk("after flush result", ResultE, last_res);
        do_op("mul_after_flush", 3'b000, 32'd3, 32'd4, 32'd12, 33);

        // Asynchronous reset in the middle of a multiply
        @(negedge clk);
        StartE = 1'b1; MulDivOpE = 3'b000; SrcAE = 32'd9; SrcBE = 32'd9;
        repeat (5) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("midop reset stall", 32'(StallE), 32'd0);
        chk("midop reset done", 32'(DoneE), 32'd0);
        chk("midop reset result", ResultE, 32'd0);
        StartE = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        do_op("mul_after_reset", 3'b000, 32'd2, 32'd3, 32'd6, 33);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
